vit_trb_mbuf: RTL and testbench

Multi-bank traceback decision buffer for the Viterbi decoder, with the xD bank control built in. The ACS side writes decision words sequentially into the current bank. Each bank is closed when it fills or on an explicit last word. The traceback engine reads closed banks at random addresses, relative to the oldest closed bank, and releases banks in order. The block sits between the ACS/decision unit and the traceback engine and replaces external ping-pong control.

---
 rtl/vit_trb_pkg.sv | 23 ++
 rtl/vit_trb_ram.sv | 25 ++
 rtl/vit_trb_mbuf.sv | 103 ++++++++++
 tb/tb_vit_trb_mbuf.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_trb_pkg.sv
// Shared widths and bank bookkeeping types
// for the Viterbi traceback decision buffer.
package vit_trb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_BANK_N = 4;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return bank_w(n) + 1;
  endfunction

  // Bank status at the default geometry.
  typedef struct packed {
    logic [bank_w(DEF_BANK_N)-1:0] ptr;
    logic [cnt_w(DEF_BANK_N)-1:0]  cnt;
    logic [DEF_BANK_N-1:0][DEF_ADDR_W:0] len;
  } bank_stat_t;

endpackage

// File: rtl/vit_trb_ram.sv
// Simple dual-port decision RAM with a
// registered, enable-gated read port.
module vit_trb_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              ena,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (ena) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vit_trb_mbuf.sv
// Multi-bank traceback decision buffer with
// built-in bank control between ACS and traceback.
module vit_trb_mbuf
  import vit_trb_pkg::*;
#(
  parameter int pDATA_W = 32,
  parameter int pADDR_W = 8,
  parameter int pBANK_N = 4
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic                       iwrite,
  input  logic                       iwlast,
  input  logic [pDATA_W-1:0]         iwdata,
  output logic                       owready,
  output logic                       owovf,
  input  logic                       ird,
  input  logic [bank_w(pBANK_N)-1:0] irbank,
  input  logic [pADDR_W-1:0]         iraddr,
  output logic [pDATA_W-1:0]         ordata,
  output logic                       orval,
  input  logic                       irrelease,
  output logic [cnt_w(pBANK_N)-1:0]  orcnt,
  output logic [pADDR_W:0]           orlen
);

  localparam int BW = bank_w(pBANK_N);
  localparam int CW = cnt_w(pBANK_N);
  localparam int LW = pADDR_W + 1;
  localparam int AW = pADDR_W + BW;

  localparam logic [CW-1:0]      FULL = CW'(pBANK_N);
  localparam logic [pADDR_W-1:0] LAST = '1;

  typedef struct packed {
    logic [BW-1:0]      wbank;
    logic [pADDR_W-1:0] waddr;
    logic [BW-1:0]      rbank;
    logic [CW-1:0]      cnt;
  } ptr_t;

  ptr_t              st;
  logic [LW-1:0]     len [pBANK_N];
  logic              wr;
  logic              close;
  logic              rel;
  logic              rd_ok;
  logic              rd_v1;
  logic [BW-1:0]     rd_bank;
  logic [pDATA_W-1:0] ram_q;

  assign owready = (st.cnt != FULL);
  assign wr      = iclkena & iwrite & owready;
  assign close   = wr & (iwlast | (st.waddr == LAST));
  assign rel     = iclkena & irrelease & (st.cnt != '0);
  assign rd_bank = st.rbank + irbank;
  assign rd_ok   = ird & ({1'b0, irbank} < st.cnt);
  assign orcnt   = st.cnt;
  assign orlen   = (st.cnt != '0) ? len[st.rbank] : '0;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      st     <= '0;
      owovf  <= 1'b0;
      rd_v1  <= 1'b0;
      orval  <= 1'b0;
      ordata <= '0;
      for (int i = 0; i < pBANK_N; i++) len[i] <= '0;
    end else if (iclkena) begin
      if (wr) begin
        if (close) begin
          st.wbank      <= st.wbank + BW'(1);
          st.waddr      <= '0;
          len[st.wbank] <= LW'(st.waddr) + LW'(1);
        end else begin
          st.waddr <= st.waddr + pADDR_W'(1);
        end
      end
      if (rel) st.rbank <= st.rbank + BW'(1);
      // Close and release together leave cnt unchanged.
      st.cnt <= st.cnt + CW'(close) - CW'(rel);
      if (iwrite & ~owready) owovf <= 1'b1;
      rd_v1  <= rd_ok;
      orval  <= rd_v1;
      ordata <= ram_q;
    end
  end

  vit_trb_ram #(
    .DATA_W (pDATA_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (iclk),
    .ena   (iclkena),
    .we    (wr),
    .waddr ({st.wbank, st.waddr}),
    .wdata (iwdata),
    .raddr ({rd_bank, iraddr}),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_vit_trb_mbuf.sv
// Scoreboard bench for vit_trb_mbuf against a
// queue-of-banks reference model.
module tb_vit_trb_mbuf;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int BN    = 2;
  localparam int BW    = 1;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          wr = 1'b0;
  logic          wl = 1'b0;
  logic [DW-1:0] wd = '0;
  logic          rdy;
  logic          ovf;
  logic          rd = 1'b0;
  logic [BW-1:0] rb = '0;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] rdata;
  logic          rval;
  logic          rel = 1'b0;
  logic [CW-1:0] cnt;
  logic [AW:0]   len;

  vit_trb_mbuf #(
    .pDATA_W (DW),
    .pADDR_W (AW),
    .pBANK_N (BN)
  ) dut (
    .iclk      (clk),
    .ireset    (rst),
    .iclkena   (ena),
    .iwrite    (wr),
    .iwlast    (wl),
    .iwdata    (wd),
    .owready   (rdy),
    .owovf     (ovf),
    .ird       (rd),
    .irbank    (rb),
    .iraddr    (ra),
    .ordata    (rdata),
    .orval     (rval),
    .irrelease (rel),
    .orcnt     (cnt),
    .orlen     (len)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] words[$];
  int            cbase[$];
  int            clen[$];
  int            cur_base = 0;
  int            cur_len = 0;
  bit            ovf_m = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            s1 = 0;
  bit            s2 = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    words.delete();
    cbase.delete();
    clen.delete();
    cur_base = 0;
    cur_len  = 0;
    ovf_m    = 0;
  endtask

  task automatic cyc(input bit e, input bit w, input bit l,
                     input logic [DW-1:0] d, input bit r, input int b,
                     input int a, input bit f);
    exp_t x;
    int   n;
    ena = e; wr = w; wl = l; wd = d;
    rd = r; rb = BW'(b); ra = AW'(a); rel = f;
    if (e) begin
      n = clen.size();
      if (r) begin
        x.v = (b < n);
        x.d = x.v ? words[cbase[b] + a] : '0;
        exp_q.push_back(x);
      end
      if (w) begin
        if (n != BN) begin
          words.push_back(d);
          cur_len++;
          if (l || cur_len == DEPTH) begin
            cbase.push_back(cur_base);
            clen.push_back(cur_len);
            cur_base = words.size();
            cur_len  = 0;
          end
        end else begin
          ovf_m = 1;
        end
      end
      if (f && n > 0) begin
        void'(cbase.pop_front());
        void'(clen.pop_front());
      end
    end
    @(posedge clk);
    #1;
    chk("orcnt", DW'(cnt), DW'(clen.size()));
    chk("orlen", DW'(len), (clen.size() > 0) ? DW'(clen[0]) : '0);
    chk("owready", DW'(rdy), DW'(clen.size() != BN));
    chk("owovf", DW'(ovf), DW'(ovf_m));
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input bit l);
    cyc(1, 1, l, d, 0, 0, 0, 0);
  endtask

  task automatic rd_word(input int b, input int a);
    cyc(1, 0, 0, '0, 1, b, a, 0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cycle();
    bit e, w, l, r, f;
    int b, a;
    e = ($urandom_range(0, 9) != 0);
    w = ($urandom_range(0, 2) != 0);
    l = ($urandom_range(0, 7) == 0);
    r = $urandom_range(0, 1) == 1;
    b = $urandom_range(0, BN - 1);
    a = (b < clen.size()) ? $urandom_range(0, clen[b] - 1)
                          : $urandom_range(0, DEPTH - 1);
    f = ($urandom_range(0, 3) == 0);
    cyc(e, w, l, $urandom, r, b, a, f);
  endtask

  task automatic reset_checks();
    chk("rst_orval", DW'(rval), '0);
    chk("rst_ordata", rdata, '0);
    chk("rst_owovf", DW'(ovf), '0);
    chk("rst_orcnt", DW'(cnt), '0);
    chk("rst_orlen", DW'(len), '0);
    chk("rst_owready", DW'(rdy), 32'd1);
  endtask

  task automatic do_reset();
    #2;
    wr = 0; rd = 0; rel = 0; wl = 0;
    rst = 1;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
  endtask

  // Output side: pops the scoreboard when a read reaches the output.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (rst) begin
        s1 = 0;
        s2 = 0;
      end else if (ena) begin
        s2 = s1;
        s1 = rd;
        #1;
        if (s2) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got read, want none at %0t", $time);
          end else begin
            x = exp_q.pop_front();
            chk("orval", DW'(rval), DW'(x.v));
            if (x.v) chk("ordata", rdata, x.d);
          end
        end else begin
          chk("orval_idle", DW'(rval), '0);
        end
      end
    end
  end

  initial begin
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 0;
    ena = 1;

    // Fill one bank, then read it back.
    for (int i = 0; i < DEPTH; i++) wr_word(32'h10 + i, 0);
    rd_word(0, 5);
    idle(2);

    // Early close, backpressure and overflow.
    for (int i = 0; i < 3; i++) wr_word(32'h20 + i, i == 2);
    wr_word(32'hdead, 0);
    rd_word(0, 5);
    rd_word(1, 2);
    cyc(1, 0, 0, '0, 0, 0, 0, 1);
    rd_word(0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 1);
    cyc(1, 0, 0, '0, 0, 0, 0, 1);
    idle(2);
    do_reset();

    // Wrap-around over several fill/release rounds.
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < BN; b++)
        for (int i = 0; i < DEPTH; i++)
          wr_word(32'h1000 * (r + 1) + 32'h100 * b + i, 0);
      for (int i = 0; i < 4; i++)
        rd_word($urandom_range(0, BN - 1), $urandom_range(0, DEPTH - 1));
      cyc(1, 0, 0, '0, 1, 1, 7, 1);
      cyc(1, 0, 0, '0, 1, 0, 3, 1);
    end
    idle(2);

    // Close and release in the same cycle with one bank closed.
    for (int i = 0; i < DEPTH; i++) wr_word(32'h500 + i, 0);
    for (int i = 0; i < DEPTH - 1; i++) wr_word(32'h600 + i, 0);
    cyc(1, 1, 0, 32'h607, 1, 0, 1, 1);
    rd_word(0, 7);
    rd_word(0, 0);
    rd_word(1, 0);
    idle(2);

    // Clock enable low freezes everything.
    rd_word(0, 4);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'hbad, 1, 0, 2, 1);
    idle(3);

    for (int i = 0; i < 600; i++) rnd_cycle();
    idle(3);

    // Reset mid-fill with a read in flight.
    cyc(1, 0, 0, '0, 0, 0, 0, 1);
    cyc(1, 0, 0, '0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) wr_word(32'h700 + i, 0);
    wr_word(32'h800, 0);
    rd_word(0, 1);
    do_reset();
    idle(2);
    for (int i = 0; i < 3; i++) wr_word(32'h900 + i, i == 2);
    rd_word(0, 2);
    idle(3);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
